// File: rtl/ws2811_pkg.sv
// -----------------------------------------------------------------------------
// ws2811_pkg
// Shared types and default timing for the WS2811 single-wire LED serializer.
//   ws2811_state_e    : serializer FSM states
//   *_DEF             : default bit timing in clock cycles for a 12 MHz clock
//   PIX_W / BIT_IDX_W : pixel word width (GRB, 8 bits each) and bit index width
// -----------------------------------------------------------------------------
package ws2811_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } ws2811_state_e;

    // 1.25 us bit period, 0.33 us / 0.67 us high times, 60 us latch at 12 MHz
    localparam int TBIT_DEF         = 15;
    localparam int T0H_DEF          = 4;
    localparam int T1H_DEF          = 8;
    localparam int RESET_CYCLES_DEF = 720;

    localparam int PIX_W     = 24;
    localparam int BIT_IDX_W = 5;

endpackage : ws2811_pkg

// File: rtl/ws2811_bit_timer.sv
// -----------------------------------------------------------------------------
// ws2811_bit_timer
// Phase counter for one WS2811 bit cell. While en is high the phase runs
// 0..TBIT-1 and reloads to zero; while en is low it is held at zero, so the
// first enabled cycle is always phase 0 of a fresh bit.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : a bit cell is being transmitted this cycle
//   bit_val     : value of the bit currently being transmitted
//   high_next   : the following cycle, if still in this bit, is a high phase
//   pre_end     : this is the second-to-last phase of the bit
//   end_of_bit  : this is the last phase of the bit
// high_next is a look-ahead so the owner can drive a registered data line
// that is already correct in the cycle it describes.
// -----------------------------------------------------------------------------
module ws2811_bit_timer #(
    parameter int TBIT = 15,
    parameter int T0H  = 4,
    parameter int T1H  = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic bit_val,
    output logic high_next,
    output logic pre_end,
    output logic end_of_bit
);

    localparam int PW  = $clog2(TBIT);
    localparam int PW1 = PW + 1;

    localparam logic [PW-1:0] LAST_PH = PW'(TBIT - 1);
    localparam logic [PW-1:0] PRE_PH  = PW'(TBIT - 2);
    localparam logic [PW:0]   T0H_W   = PW1'(T0H);
    localparam logic [PW:0]   T1H_W   = PW1'(T1H);

    logic [PW-1:0] phase_r;
    logic [PW:0]   phase_inc_s;
    logic [PW:0]   thr_s;

    // Phase counter: runs only while enabled, reloads to zero at end of bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_r <= PW'(0);
        end else if (!en) begin
            phase_r <= PW'(0);
        end else if (phase_r == LAST_PH) begin
            phase_r <= PW'(0);
        end else begin
            phase_r <= phase_r + PW'(1);
        end
    end

    // Threshold select and look-ahead comparison against the next phase.
    always_comb begin
        phase_inc_s = {1'b0, phase_r} + PW1'(1);
        if (bit_val) begin
            thr_s = T1H_W;
        end else begin
            thr_s = T0H_W;
        end
        high_next  = en && (phase_inc_s < thr_s);
        pre_end    = en && (phase_r == PRE_PH);
        end_of_bit = en && (phase_r == LAST_PH);
    end

endmodule : ws2811_bit_timer

// File: rtl/ws2811_serializer.sv
// -----------------------------------------------------------------------------
// ws2811_serializer
// Accepts 24-bit GRB pixels over valid/ready and drives the WS2811 NRZ data
// line, MSB first. After a pixel flagged as last, the line is held low for
// RESET_CYCLES cycles and FRAME_DONE pulses in the final latch cycle.
// Ports:
//   CLKIN       : clock
//   RSTN        : asynchronous active-low reset
//   PIX_DATA    : pixel {G,R,B}
//   PIX_VALID   : PIX_DATA / PIX_LAST valid
//   PIX_LAST    : pixel closes the frame
//   PIX_READY   : pixel accepted on this cycle's rising edge if valid
//   DOUT        : registered WS2811 data line
//   BUSY        : a pixel or latch interval is in progress
//   FRAME_DONE  : one-cycle pulse in the last latch cycle
// All outputs are registered: each register is loaded with the value the
// output must show in the cycle after the edge, computed from the next state.
// -----------------------------------------------------------------------------
module ws2811_serializer
    import ws2811_pkg::*;
#(
    parameter int TBIT         = TBIT_DEF,
    parameter int T0H          = T0H_DEF,
    parameter int T1H          = T1H_DEF,
    parameter int RESET_CYCLES = RESET_CYCLES_DEF
) (
    input  logic             CLKIN,
    input  logic             RSTN,
    input  logic [PIX_W-1:0] PIX_DATA,
    input  logic             PIX_VALID,
    input  logic             PIX_LAST,
    output logic             PIX_READY,
    output logic             DOUT,
    output logic             BUSY,
    output logic             FRAME_DONE
);

    if (!(T0H > 0 && T0H < T1H && T1H < TBIT && RESET_CYCLES >= 1)) begin : g_bad_params
        $error("ws2811_serializer: timing parameters must satisfy 0 < T0H < T1H < TBIT and RESET_CYCLES >= 1");
    end

    localparam int LW = $clog2(RESET_CYCLES + 1);
    localparam logic [LW-1:0]        LAST_LATCH = LW'(RESET_CYCLES - 1);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT   = BIT_IDX_W'(PIX_W - 1);

    ws2811_state_e          state_r;
    ws2811_state_e          state_nxt_s;
    logic [PIX_W-1:0]       shreg_r;
    logic                   last_r;
    logic [BIT_IDX_W-1:0]   bit_idx_r;
    logic [LW-1:0]          latch_cnt_r;
    logic [LW-1:0]          latch_cnt_nxt_s;

    logic                   dout_r;
    logic                   busy_r;
    logic                   frame_done_r;
    logic                   ready_r;
    logic                   dout_nxt_s;
    logic                   busy_nxt_s;
    logic                   frame_done_nxt_s;
    logic                   ready_nxt_s;

    logic                   transfer_s;
    logic                   shifting_s;
    logic                   high_next_s;
    logic                   pre_end_s;
    logic                   end_of_bit_s;
    logic                   eop_s;
    logic                   latch_end_s;

    assign transfer_s  = PIX_VALID && ready_r;
    assign shifting_s  = (state_r == SHIFT);
    assign eop_s       = end_of_bit_s && (bit_idx_r == LAST_BIT);
    assign latch_end_s = (state_r == LATCH) && (latch_cnt_r == LAST_LATCH);

    ws2811_bit_timer #(
        .TBIT (TBIT),
        .T0H  (T0H),
        .T1H  (T1H)
    ) u_bit_timer (
        .clk        (CLKIN),
        .rst_n      (RSTN),
        .en         (shifting_s),
        .bit_val    (shreg_r[PIX_W-1]),
        .high_next  (high_next_s),
        .pre_end    (pre_end_s),
        .end_of_bit (end_of_bit_s)
    );

    // FSM state register.
    always_ff @(posedge CLKIN or negedge RSTN) begin
        if (!RSTN) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (transfer_s) begin
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (!eop_s) begin
                    state_nxt_s = SHIFT;
                end else if (last_r) begin
                    state_nxt_s = LATCH;
                end else if (transfer_s) begin
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LATCH: begin
                if (latch_end_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = LATCH;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM outputs: values the output registers must present next cycle.
    always_comb begin
        if ((state_nxt_s == LATCH) && (state_r == LATCH)) begin
            latch_cnt_nxt_s = latch_cnt_r + LW'(1);
        end else begin
            latch_cnt_nxt_s = LW'(0);
        end

        // A newly started bit (from IDLE or after end_of_bit) always opens
        // with a high phase because T0H > 0.
        if (state_nxt_s == SHIFT) begin
            dout_nxt_s = !shifting_s || end_of_bit_s || high_next_s;
        end else begin
            dout_nxt_s = 1'b0;
        end

        busy_nxt_s       = (state_nxt_s != IDLE);
        frame_done_nxt_s = (state_nxt_s == LATCH) && (latch_cnt_nxt_s == LAST_LATCH);

        // Ready in IDLE, or in the coming end-of-pixel cycle of a non-last pixel.
        if (state_nxt_s == IDLE) begin
            ready_nxt_s = 1'b1;
        end else if (shifting_s && (bit_idx_r == LAST_BIT) && pre_end_s && !last_r) begin
            ready_nxt_s = 1'b1;
        end else begin
            ready_nxt_s = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge CLKIN or negedge RSTN) begin
        if (!RSTN) begin
            dout_r       <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            ready_r      <= 1'b0;
        end else begin
            dout_r       <= dout_nxt_s;
            busy_r       <= busy_nxt_s;
            frame_done_r <= frame_done_nxt_s;
            ready_r      <= ready_nxt_s;
        end
    end

    // Pixel shift register, last flag, bit index and latch counter.
    always_ff @(posedge CLKIN or negedge RSTN) begin
        if (!RSTN) begin
            shreg_r     <= {PIX_W{1'b0}};
            last_r      <= 1'b0;
            bit_idx_r   <= BIT_IDX_W'(0);
            latch_cnt_r <= LW'(0);
        end else begin
            latch_cnt_r <= latch_cnt_nxt_s;
            if (transfer_s) begin
                shreg_r   <= PIX_DATA;
                last_r    <= PIX_LAST;
                bit_idx_r <= BIT_IDX_W'(0);
            end else if (eop_s) begin
                shreg_r   <= {shreg_r[PIX_W-2:0], 1'b0};
                last_r    <= last_r;
                bit_idx_r <= BIT_IDX_W'(0);
            end else if (end_of_bit_s) begin
                shreg_r   <= {shreg_r[PIX_W-2:0], 1'b0};
                last_r    <= last_r;
                bit_idx_r <= bit_idx_r + BIT_IDX_W'(1);
            end else begin
                shreg_r   <= shreg_r;
                last_r    <= last_r;
                bit_idx_r <= bit_idx_r;
            end
        end
    end

    assign PIX_READY  = ready_r;
    assign DOUT       = dout_r;
    assign BUSY       = busy_r;
    assign FRAME_DONE = frame_done_r;

endmodule : ws2811_serializer
